rca_ou_lsq: RTL

- Per-OU load/store queue: the responder side of the OU LSQ request interface.
- Accepts addr/data/fn3/load/store requests from one reconfigurable-accelerator OU and buffers them in order.
- Issues them to a word-addressed data-memory port with byte enables, returning sign/zero-extended load results to the OU.
- Sits between the OU and the RCA memory arbiter.

---
 rtl/rca_ou_lsq_if.sv | 41 ++++
 rtl/rca_ou_lsq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rca_ou_lsq_if.sv
// Request/response bundle between one reconfigurable-accelerator OU, its
// load/store queue and the data-memory arbiter port.
interface rca_ou_lsq_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            load;
    logic            store;
    logic            new_request;
    logic            lsq_full;
    logic [XLEN-1:0] load_data;
    logic            load_complete;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_be;
    logic            mem_load;
    logic            mem_store;
    logic            mem_rd_valid;
    logic [XLEN-1:0] mem_rd_data;

    // Environment side: the OU plus the memory arbiter.
    modport master (
        output flush, addr, data, fn3, load, store, new_request,
               mem_req_ready, mem_rd_valid, mem_rd_data,
        input  lsq_full, load_data, load_complete, mem_req_valid,
               mem_addr, mem_wdata, mem_be, mem_load, mem_store
    );

    // Queue side.
    modport slave (
        input  flush, addr, data, fn3, load, store, new_request,
               mem_req_ready, mem_rd_valid, mem_rd_data,
        output lsq_full, load_data, load_complete, mem_req_valid,
               mem_addr, mem_wdata, mem_be, mem_load, mem_store
    );
endinterface

// File: rtl/rca_ou_lsq.sv
// Per-OU load/store queue: buffers OU requests in order, issues them to a
// word-addressed memory port with byte enables and returns extended loads.
// At most one load is outstanding; issue stalls until its data returns.
module rca_ou_lsq #(
    parameter int LSQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    rca_ou_lsq_if.slave bus
);
    localparam int XLEN = 32;
    localparam int PW   = $clog2(LSQ_DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(LSQ_DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LOAD = 2'd1,
        ST_DRAIN     = 2'd2
    } state_t;

    // Replicate store data across the byte lanes selected by the access size.
    function automatic logic [XLEN-1:0] fmt_wdata(logic [1:0] sz, logic [XLEN-1:0] d);
        logic [XLEN-1:0] w;
        case (sz)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Byte enables; address bits below the access size are ignored.
    function automatic logic [3:0] fmt_be(logic [1:0] sz, logic [1:0] a);
        logic [3:0] be;
        case (sz)
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Pick the addressed byte/half of the raw word and sign/zero extend it.
    function automatic logic [XLEN-1:0] ext_load(logic [2:0] f, logic [1:0] a, logic [XLEN-1:0] w);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        case (a)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    logic [XLEN-1:0] q_addr_q [LSQ_DEPTH];
    logic [XLEN-1:0] q_addr_d [LSQ_DEPTH];
    logic [XLEN-1:0] q_data_q [LSQ_DEPTH];
    logic [XLEN-1:0] q_data_d [LSQ_DEPTH];
    logic [2:0]      q_fn3_q  [LSQ_DEPTH];
    logic [2:0]      q_fn3_d  [LSQ_DEPTH];
    logic            q_load_q [LSQ_DEPTH];
    logic            q_load_d [LSQ_DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            lsq_full_q, lsq_full_d;
    state_t          state_q, state_d;
    logic [2:0]      lat_fn3_q, lat_fn3_d;
    logic [1:0]      lat_off_q, lat_off_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic            load_complete_q, load_complete_d;

    logic [XLEN-1:0] head_addr_s, head_data_s;
    logic [2:0]      head_fn3_s;
    logic            head_load_s, req_valid_s, enq_s, deq_s;

    // Head entry and the enqueue/dequeue handshakes for this cycle.
    always_comb begin
        head_addr_s = q_addr_q[rd_ptr_q];
        head_data_s = q_data_q[rd_ptr_q];
        head_fn3_s  = q_fn3_q[rd_ptr_q];
        head_load_s = q_load_q[rd_ptr_q];
        req_valid_s = (count_q != '0) && (state_q == ST_IDLE);
        deq_s       = req_valid_s && bus.mem_req_ready;
        enq_s       = bus.new_request && (bus.load ^ bus.store) && !lsq_full_q && !bus.flush;
    end

    // Queue storage, pointers and occupancy; flush empties everything.
    always_comb begin
        q_addr_d = q_addr_q;
        q_data_d = q_data_q;
        q_fn3_d  = q_fn3_q;
        q_load_d = q_load_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_s) begin
                q_addr_d[wr_ptr_q] = bus.addr;
                q_data_d[wr_ptr_q] = bus.data;
                q_fn3_d[wr_ptr_q]  = bus.fn3;
                q_load_d[wr_ptr_q] = bus.load;
                wr_ptr_d           = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_s, deq_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
        lsq_full_d = (count_d == CNT_FULL);
    end

    // Load-tracking FSM: blocks issue while a load is outstanding and
    // swallows the response of a load orphaned by a flush.
    always_comb begin
        state_d         = state_q;
        lat_fn3_d       = lat_fn3_q;
        lat_off_d       = lat_off_q;
        load_data_d     = load_data_q;
        load_complete_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (deq_s && head_load_s) begin
                    state_d   = bus.flush ? ST_DRAIN : ST_WAIT_LOAD;
                    lat_fn3_d = head_fn3_s;
                    lat_off_d = head_addr_s[1:0];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_LOAD: begin
                if (bus.mem_rd_valid) begin
                    state_d         = ST_IDLE;
                    load_data_d     = ext_load(lat_fn3_q, lat_off_q, bus.mem_rd_data);
                    load_complete_d = 1'b1;
                end else if (bus.flush) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_WAIT_LOAD;
                end
            end
            ST_DRAIN: begin
                if (bus.mem_rd_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            lsq_full_q      <= 1'b0;
            state_q         <= ST_IDLE;
            lat_fn3_q       <= 3'd0;
            lat_off_q       <= 2'd0;
            load_data_q     <= '0;
            load_complete_q <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            lsq_full_q      <= lsq_full_d;
            state_q         <= state_d;
            lat_fn3_q       <= lat_fn3_d;
            lat_off_q       <= lat_off_d;
            load_data_q     <= load_data_d;
            load_complete_q <= load_complete_d;
        end
    end

    // Queue payload; only meaningful where count marks an entry valid.
    always_ff @(posedge clk) begin
        q_addr_q <= q_addr_d;
        q_data_q <= q_data_d;
        q_fn3_q  <= q_fn3_d;
        q_load_q <= q_load_d;
    end

    assign bus.lsq_full      = lsq_full_q;
    assign bus.load_data     = load_data_q;
    assign bus.load_complete = load_complete_q;
    assign bus.mem_req_valid = req_valid_s;
    assign bus.mem_addr      = {head_addr_s[XLEN-1:2], 2'b00};
    assign bus.mem_wdata     = head_load_s ? '0 : fmt_wdata(head_fn3_s[1:0], head_data_s);
    assign bus.mem_be        = fmt_be(head_fn3_s[1:0], head_addr_s[1:0]);
    assign bus.mem_load      = req_valid_s && head_load_s;
    assign bus.mem_store     = req_valid_s && !head_load_s;
endmodule
